// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches one word per instruction over a
// req/ready port and holds it in the instruction register for decode.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h3000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [15:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [15:0]      imem_rdata,
  output logic [15:0]      instruction,
  output logic             instr_valid,
  output logic [15:0]      pc,
  input  logic             exec_done,
  input  logic             redirect,
  input  logic [15:0]      redirect_target,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t state;
  state_t state_n;

  logic fetch;
  logic retire;

  logic [15:0]      pc_q;
  logic [15:0]      ir_q;
  logic [CNT_W-1:0] cnt_q;

  assign fetch  = (state == S_REQ) && imem_ready;
  assign retire = (state == S_HOLD) && exec_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_REQ;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_REQ: begin
        if (imem_ready) state_n = S_HOLD;
      end
      S_HOLD: begin
        if (exec_done) state_n = S_REQ;
      end
      default: state_n = S_REQ;
    endcase
  end

  // request is masked while rst is high so a reset cycle never issues
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (state)
      S_REQ:   imem_req    = !rst;
      S_HOLD:  instr_valid = 1'b1;
      default: begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (fetch) begin
      pc_q <= pc_q + 16'd1;
    end else if (retire && redirect) begin
      pc_q <= redirect_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q <= 16'h0000;
    end else if (fetch) begin
      ir_q <= imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (retire) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign instruction   = ir_q;
  assign retired_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed steps then randomized traffic, all outputs
// compared every cycle with a transaction-level reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [15:0] pc;
  logic        exec_done;
  logic        redirect;
  logic [15:0] redirect_target;
  logic [31:0] retired_count;

  int checks   = 0;
  int failures = 0;

  logic [15:0] m_pc;
  logic [15:0] m_ir;
  logic        m_busy;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC(16'h3000),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .instruction(instruction),
    .instr_valid(instr_valid),
    .pc(pc),
    .exec_done(exec_done),
    .redirect(redirect),
    .redirect_target(redirect_target),
    .retired_count(retired_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // model: one instruction in flight, busy = word held awaiting execute
  task automatic model_edge();
    if (rst) begin
      m_pc   = 16'h3000;
      m_ir   = 16'h0000;
      m_busy = 1'b0;
      m_cnt  = 0;
    end else if (!m_busy) begin
      if (imem_ready) begin
        m_ir   = imem_rdata;
        m_pc   = m_pc + 16'd1;
        m_busy = 1'b1;
      end
    end else if (exec_done) begin
      m_cnt  = m_cnt + 1;
      m_busy = 1'b0;
      if (redirect) m_pc = redirect_target;
    end
  endtask

  task automatic cyc(input logic r, input logic rdy, input logic [15:0] d,
                     input logic ed, input logic rd, input logic [15:0] t);
    rst             = r;
    imem_ready      = rdy;
    imem_rdata      = d;
    exec_done       = ed;
    redirect        = rd;
    redirect_target = t;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("req", {31'd0, imem_req}, {31'd0, !m_busy && !rst});
    chk("addr", {16'd0, imem_addr}, {16'd0, m_pc});
    chk("pc", {16'd0, pc}, {16'd0, m_pc});
    chk("instr", {16'd0, instruction}, {16'd0, m_ir});
    chk("valid", {31'd0, instr_valid}, {31'd0, m_busy});
    chk("count", retired_count, m_cnt);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    rst = 1'b1; imem_ready = 1'b0; imem_rdata = '0;
    exec_done = 1'b0; redirect = 1'b0; redirect_target = '0;
    m_pc = 16'h3000; m_ir = '0; m_busy = 1'b0; m_cnt = 0;
    @(negedge clk);

    // 1: zero-wait sequential fetch
    cyc(1'b1, 1'b1, 16'h1042, 1'b0, 1'b0, 16'h0);
    chk("t1_rst_req", {31'd0, imem_req}, 32'd0);
    chk("t1_rst_valid", {31'd0, instr_valid}, 32'd0);
    idle();
    chk("t1_addr0", {16'd0, imem_addr}, 32'h3000);
    cyc(1'b0, 1'b1, 16'h1042, 1'b0, 1'b0, 16'h0);
    chk("t1_pc_held", {16'd0, pc}, 32'h3001);
    chk("t1_instr", {16'd0, instruction}, 32'h1042);
    chk("t1_valid1", {31'd0, instr_valid}, 32'd1);
    cyc(1'b0, 1'b1, 16'h1042, 1'b1, 1'b0, 16'h0);
    chk("t1_addr1", {16'd0, imem_addr}, 32'h3001);
    chk("t1_valid0", {31'd0, instr_valid}, 32'd0);
    cyc(1'b0, 1'b1, 16'h1042, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b1, 16'h1042, 1'b1, 1'b0, 16'h0);
    chk("t1_addr2", {16'd0, imem_addr}, 32'h3002);
    cyc(1'b0, 1'b1, 16'h1042, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 16'h1042, 1'b1, 1'b0, 16'h0);
    chk("t1_count3", retired_count, 32'd3);

    // 2: memory wait states
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 16'hBEEF, 1'b0, 1'b0, 16'h0);
      chk("t2_req", {31'd0, imem_req}, 32'd1);
      chk("t2_addr", {16'd0, imem_addr}, 32'h3000);
      chk("t2_noload", {16'd0, instruction}, 32'h0000);
    end
    cyc(1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0);
    chk("t2_load", {16'd0, instruction}, 32'hBEEF);
    chk("t2_valid", {31'd0, instr_valid}, 32'd1);

    // 3: taken redirect from hold
    cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h4000);
    chk("t3_addr", {16'd0, imem_addr}, 32'h4000);
    chk("t3_count", retired_count, 32'd1);
    cyc(1'b0, 1'b1, 16'h5555, 1'b0, 1'b0, 16'h0);
    chk("t3_pc", {16'd0, pc}, 32'h4001);

    // 4: execute signals ignored while requesting
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h1234);
    cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h1234);
    chk("t4_addr", {16'd0, imem_addr}, 32'h3000);
    chk("t4_count", retired_count, 32'd0);
    chk("t4_valid", {31'd0, instr_valid}, 32'd0);

    // 5: PC wrap
    cyc(1'b0, 1'b1, 16'h0E01, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'hFFFF);
    cyc(1'b0, 1'b1, 16'h0E02, 1'b0, 1'b0, 16'h0);
    chk("t5_wrap", {16'd0, pc}, 32'h0000);
    cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    chk("t5_addr", {16'd0, imem_addr}, 32'h0000);

    // 6: reset with an outstanding request
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 16'h2000, 1'b0, 1'b0, 16'h0);
      cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    end
    idle();
    chk("t6_addr", {16'd0, imem_addr}, 32'h3005);
    cyc(1'b1, 1'b1, 16'hDEAD, 1'b1, 1'b1, 16'h7777);
    chk("t6_pc", {16'd0, pc}, 32'h3000);
    chk("t6_instr", {16'd0, instruction}, 32'h0000);
    chk("t6_valid", {31'd0, instr_valid}, 32'd0);
    chk("t6_count", retired_count, 32'd0);
    chk("t6_req", {31'd0, imem_req}, 32'd0);

    // randomized traffic incl. self-loop redirects and rare resets
    for (int i = 0; i < 400; i++) begin
      logic [15:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? m_pc - 16'd1 : 16'($urandom);
      cyc($urandom_range(0, 49) == 0, 1'($urandom), 16'($urandom),
          1'($urandom), 1'($urandom), tgt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the instruction decoder.
- Owns the program counter and issues word reads to instruction memory over a req/ready handshake.
- Holds each fetched instruction in an instruction register that drives the decoder.
- Advances or redirects the PC when the execute stage signals completion, using the resolved branch/JMP result.

Parameters:
- RESET_PC, 16'h3000, PC value loaded on reset; address of the first fetch.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  read request to instruction memory.
- imem_addr  output  16  word address of the request.
- imem_ready  input  1  memory returns data this cycle; sampled only while imem_req=1.
- imem_rdata  input  16  instruction word; valid when imem_req && imem_ready.
- instruction  output  16  instruction register contents, fed to the decoder.
- instr_valid  output  1  instruction register holds an instruction not yet executed.
- pc  output  16  incremented PC (address of held instruction + 1); used by the LEA path.
- exec_done  input  1  one-cycle pulse: execute stage has finished the held instruction.
- redirect  input  1  with exec_done: taken BR or JMP.
- redirect_target  input  16  next fetch address when redirect=1.
- retired_count  output  CNT_W  number of exec_done pulses accepted since reset.

Behaviour:
- Reset values (rst=1 at a rising edge): state=S_REQ; pc=RESET_PC; instruction=16'h0000 (BR with nzp=000, never taken); instr_valid=0; retired_count=0; imem_req=0 during the reset cycle.
- FSM states:
  - S_REQ:
    - imem_req=1, imem_addr=pc.
    - imem_addr must stay stable until imem_ready.
    - On imem_req && imem_ready: instruction<=imem_rdata; pc<=pc+1; go to S_HOLD.
  - S_HOLD:
    - imem_req=0; instr_valid=1; instruction held constant.
    - On exec_done: retired_count<=retired_count+1; go to S_REQ.
    - If redirect=1, pc<=redirect_target; otherwise pc is unchanged (already incremented).
- Outputs instr_valid and imem_req are decoded from the state register (Moore).
- imem_addr is driven directly from the pc register.
- Zero-wait memory: imem_ready may be high in the first S_REQ cycle, giving 1 cycle in S_REQ.
- Minimum instruction period is 2 cycles (S_REQ, then S_HOLD with exec_done in its first cycle).
- Arithmetic:
  - pc+1 is modulo 2^16; 16'hFFFF wraps to 16'h0000.
  - retired_count wraps modulo 2^CNT_W.
- exec_done or redirect asserted in S_REQ: ignored; no state, pc or counter change.
- redirect without exec_done: ignored.
- redirect_target equal to the address just fetched: legal; refetch of the same word (self-loop).
- imem_ready while imem_req=0: ignored; imem_rdata is not sampled.
- Reset mid-operation (either state, including an outstanding request): all state returns to reset values next edge; a pending memory response is discarded.
- rst has priority over all other inputs in the same cycle.
- pc output between fetches holds fetched address+1, so a decoder selecting ssel=01 (LEA) sees the LC-3 incremented PC.

Test Plan:
1. Reset, imem_ready tied 1, rdata=16'h1042, exec_done pulsed in each S_HOLD -> imem_addr sequence 3000,3001,3002; instr_valid alternates 0/1; pc=3001 while the first instruction is held; retired_count=3 after three pulses.
2. imem_ready held low 4 cycles after req -> imem_req and imem_addr=3000 stable for 5 cycles; instruction loads on the ready cycle only; instr_valid rises the following cycle.
3. In S_HOLD, exec_done=1, redirect=1, target=16'h4000 -> next imem_addr=4000; pc then 4001 after the fetch; retired_count increments by 1.
4. exec_done and redirect pulsed during S_REQ with imem_ready=0 -> pc, state and retired_count unchanged; imem_addr remains 3000.
5. Redirect to 16'hFFFF, fetch completes -> pc=16'h0000; the next sequential fetch address is 0000.
6. rst asserted while waiting on imem_ready at addr 3005 -> next cycle pc=3000, instruction=0000, instr_valid=0, retired_count=0; a late imem_ready during reset is ignored.
